// File: rtl/ysyx_25040129_csr_ctrl_if.sv
// ysyx_25040129_csr_ctrl_if
//   Bundles the two valid/ready channels of the CSR/system-instruction
//   sequencer: the IDU -> sequencer instruction channel (in_*) and the
//   sequencer -> WBU result channel (out_*).
//   master : the IDU/WBU side (drives in_* and out_ready).
//   slave  : the sequencer side (drives in_ready and out_*).
interface ysyx_25040129_csr_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_addr;
  logic [31:0] in_rs1_val;
  logic [4:0]  in_zimm;
  logic        in_rs1_zero;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic        out_rd_we;
  logic        out_redirect;
  logic [31:0] out_target;

  modport master (
    output in_valid, in_kind, in_funct3, in_csr_addr, in_rs1_val, in_zimm,
           in_rs1_zero, in_pc, out_ready,
    input  in_ready, out_valid, out_rd_data, out_rd_we, out_redirect, out_target
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_csr_addr, in_rs1_val, in_zimm,
           in_rs1_zero, in_pc, out_ready,
    output in_ready, out_valid, out_rd_data, out_rd_we, out_redirect, out_target
  );
endinterface

// File: rtl/ysyx_25040129_csr_ctrl.sv
// ysyx_25040129_csr_ctrl
//   System-instruction sequencer. Accepts one Zicsr/ecall/mret/illegal
//   instruction at a time, reads the CSR file, issues exactly one strobe
//   (csr_write, ecall or mret) and returns rd data or a PC redirect.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     bus (slave)     in_* instruction channel, out_* result channel
//     csr_read_addr   combinational read address to the CSR file
//     csr_rdata       CSR read data (same cycle)
//     csr_write, csr_write_addr, csr_data   one-cycle CSR write
//     ecall, mret     one-cycle trap / return strobes
//     mepc_data, mcause_data                values loaded on ecall/mret
module ysyx_25040129_csr_ctrl (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25040129_csr_ctrl_if.slave       bus,
  output logic [11:0]                   csr_read_addr,
  input  logic [31:0]                   csr_rdata,
  output logic                          csr_write,
  output logic [11:0]                   csr_write_addr,
  output logic [31:0]                   csr_data,
  output logic                          ecall,
  output logic                          mret,
  output logic [31:0]                   mepc_data,
  output logic [31:0]                   mcause_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0]  K_ZICSR   = 2'b00;
  localparam logic [1:0]  K_ECALL   = 2'b01;
  localparam logic [1:0]  K_MRET    = 2'b10;
  localparam logic [1:0]  K_ILLEGAL = 2'b11;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;

  state_t      state;

  logic [1:0]  kind_p0;
  logic [2:0]  funct3_p0;
  logic [11:0] addr_p0;
  logic [31:0] rs1_p0;
  logic [4:0]  zimm_p0;
  logic        rs1_zero_p0;
  logic [31:0] pc_p0;
  logic        illegal_p0;
  logic [31:0] old_p1;

  logic        csr_write_q;
  logic        ecall_q;
  logic        mret_q;

  logic [31:0] src;
  logic [31:0] wdata;
  logic        do_write;

  function automatic logic legal_addr(input logic [11:0] a);
    case (a)
      12'h114, 12'h514, 12'h300, 12'h305, 12'h341, 12'h342: legal_addr = 1'b1;
      default:                                              legal_addr = 1'b0;
    endcase
  endfunction

  // funct3 x00 is not a Zicsr op; unknown CSR addresses trap as well.
  function automatic logic is_illegal(input logic [1:0] kind, input logic [2:0] f3,
                                      input logic [11:0] a);
    is_illegal = (kind == K_ILLEGAL) ||
                 ((kind == K_ZICSR) && ((f3[1:0] == 2'b00) || !legal_addr(a)));
  endfunction

  // Traps (ecall or illegal) read mtvec, mret reads mepc.
  function automatic logic [11:0] read_target(input logic [1:0] kind, input logic illegal,
                                              input logic [11:0] a);
    if (illegal || kind == K_ECALL) read_target = A_MTVEC;
    else if (kind == K_MRET)        read_target = A_MEPC;
    else                            read_target = a;
  endfunction

  // Read-modify-write datapath, evaluated while csr_rdata is valid in READ.
  always_comb begin
    src = funct3_p0[2] ? {27'b0, zimm_p0} : rs1_p0;
    case (funct3_p0[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = csr_rdata | src;
      default: wdata = csr_rdata & ~src;
    endcase
    // Set/clear with a zero source must not touch the CSR (side-effect free read).
    do_write = (funct3_p0[1:0] == 2'b01) ||
               (funct3_p0[2] ? (zimm_p0 != 5'd0) : !rs1_zero_p0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      csr_read_addr    <= 12'd0;
      csr_write_q      <= 1'b0;
      ecall_q          <= 1'b0;
      mret_q           <= 1'b0;
      csr_write_addr   <= 12'd0;
      csr_data         <= 32'd0;
      mepc_data        <= 32'd0;
      mcause_data      <= 32'd0;
      bus.out_rd_data  <= 32'd0;
      bus.out_rd_we    <= 1'b0;
      bus.out_redirect <= 1'b0;
      bus.out_target   <= 32'd0;
    end else begin
      case (state)
        // Stage 0: accept and latch the instruction, point the CSR read.
        S_IDLE: begin
          if (bus.in_valid) begin
            kind_p0       <= bus.in_kind;
            funct3_p0     <= bus.in_funct3;
            addr_p0       <= bus.in_csr_addr;
            rs1_p0        <= bus.in_rs1_val;
            zimm_p0       <= bus.in_zimm;
            rs1_zero_p0   <= bus.in_rs1_zero;
            pc_p0         <= bus.in_pc;
            illegal_p0    <= is_illegal(bus.in_kind, bus.in_funct3, bus.in_csr_addr);
            csr_read_addr <= read_target(bus.in_kind,
                                         is_illegal(bus.in_kind, bus.in_funct3, bus.in_csr_addr),
                                         bus.in_csr_addr);
            state         <= S_READ;
          end
        end
        // Stage 1: capture old value and register the single strobe.
        S_READ: begin
          old_p1        <= csr_rdata;
          csr_read_addr <= 12'd0;
          if (illegal_p0) begin
            ecall_q     <= 1'b1;
            mepc_data   <= pc_p0;
            mcause_data <= 32'd2;
          end else if (kind_p0 == K_ECALL) begin
            ecall_q     <= 1'b1;
            mepc_data   <= pc_p0;
            mcause_data <= 32'd11;
          end else if (kind_p0 == K_MRET) begin
            // Writing back the value just read keeps mepc unchanged.
            mret_q      <= 1'b1;
            mepc_data   <= csr_rdata;
          end else if (do_write) begin
            csr_write_q    <= 1'b1;
            csr_write_addr <= addr_p0;
            csr_data       <= wdata;
          end
          state <= S_WRITE;
        end
        // Stage 2: strobes retire, build the WBU response.
        S_WRITE: begin
          csr_write_q    <= 1'b0;
          ecall_q        <= 1'b0;
          mret_q         <= 1'b0;
          csr_write_addr <= 12'd0;
          csr_data       <= 32'd0;
          mepc_data      <= 32'd0;
          mcause_data    <= 32'd0;
          if (!illegal_p0 && kind_p0 == K_ZICSR) begin
            bus.out_rd_data  <= old_p1;
            bus.out_rd_we    <= 1'b1;
            bus.out_redirect <= 1'b0;
            bus.out_target   <= 32'd0;
          end else begin
            bus.out_rd_data  <= 32'd0;
            bus.out_rd_we    <= 1'b0;
            bus.out_redirect <= 1'b1;
            bus.out_target   <= old_p1;
          end
          state <= S_RESP;
        end
        // Stage 3: hold the response until the WBU takes it.
        S_RESP: begin
          if (bus.out_ready) begin
            bus.out_rd_data  <= 32'd0;
            bus.out_rd_we    <= 1'b0;
            bus.out_redirect <= 1'b0;
            bus.out_target   <= 32'd0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are masked by rst so a reset arriving mid-instruction
  // suppresses the strobe in that very cycle.
  assign csr_write     = csr_write_q & ~rst;
  assign ecall         = ecall_q & ~rst;
  assign mret          = mret_q & ~rst;
  assign bus.in_ready  = (state == S_IDLE) & ~rst;
  assign bus.out_valid = (state == S_RESP) & ~rst;

endmodule

// File: tb/tb_ysyx_25040129_csr_ctrl.sv
module tb_ysyx_25040129_csr_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_rdata;
  logic        csr_write;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;
  logic        ecall;
  logic        mret;
  logic [31:0] mepc_data;
  logic [31:0] mcause_data;

  ysyx_25040129_csr_ctrl_if bus ();

  ysyx_25040129_csr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .csr_read_addr  (csr_read_addr),
    .csr_rdata      (csr_rdata),
    .csr_write      (csr_write),
    .csr_write_addr (csr_write_addr),
    .csr_data       (csr_data),
    .ecall          (ecall),
    .mret           (mret),
    .mepc_data      (mepc_data),
    .mcause_data    (mcause_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // CSR file the DUT talks to.
  logic [11:0] legal [6] = '{12'h114, 12'h514, 12'h300, 12'h305, 12'h341, 12'h342};
  logic [31:0] init_val [6];
  logic [31:0] file_mem [4096];
  logic        load_req = 1'b1;

  assign csr_rdata = file_mem[csr_read_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 6; i++) file_mem[legal[i]] <= init_val[i];
    end else begin
      if (csr_write) file_mem[csr_write_addr] <= csr_data;
      if (ecall) begin
        file_mem[12'h341] <= mepc_data;
        file_mem[12'h342] <= mcause_data;
      end
      if (mret) file_mem[12'h341] <= mepc_data;
    end
  end

  // Reference model: architectural CSR state plus expected transaction effects.
  logic [31:0] ref_csr [bit [11:0]];
  logic [11:0] exp_raddr, exp_waddr;
  logic [31:0] exp_wdata, exp_mepc, exp_mcause, exp_rd_data, exp_target;
  logic        exp_wr, exp_ecall, exp_mret, exp_rd_we, exp_redirect, exp_zicsr;
  logic [31:0] last_rd, last_target, last_wdata;

  task automatic predict(input logic [1:0] kind, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] rs1, input logic [4:0] zimm, input logic rs1z,
                         input logic [31:0] pc);
    logic        bad;
    logic [31:0] old, src, nv;
    int          op;
    exp_raddr = 0; exp_waddr = 0; exp_wdata = 0; exp_mepc = 0; exp_mcause = 0;
    exp_rd_data = 0; exp_target = 0; exp_wr = 0; exp_ecall = 0; exp_mret = 0;
    exp_rd_we = 0; exp_redirect = 0; exp_zicsr = 0;
    bad = (kind == 2'd3) ||
          (kind == 2'd0 && (f3 == 3'd0 || f3 == 3'd4 || !ref_csr.exists(a)));
    if (bad || kind == 2'd1) begin
      exp_raddr    = 12'h305;
      exp_ecall    = 1;
      exp_mepc     = pc;
      exp_mcause   = bad ? 32'd2 : 32'd11;
      exp_redirect = 1;
      exp_target   = ref_csr[12'h305];
      ref_csr[12'h341] = pc;
      ref_csr[12'h342] = exp_mcause;
    end else if (kind == 2'd2) begin
      exp_raddr    = 12'h341;
      exp_mret     = 1;
      exp_mepc     = ref_csr[12'h341];
      exp_redirect = 1;
      exp_target   = ref_csr[12'h341];
    end else begin
      exp_raddr   = a;
      old         = ref_csr[a];
      src         = (f3 >= 3'd5) ? {27'd0, zimm} : rs1;
      op          = int'(f3) % 4;
      if (op == 1)      nv = src;
      else if (op == 2) nv = old | src;
      else              nv = old & ~src;
      exp_wr      = (op == 1) || ((f3 >= 3'd5) ? (zimm != 0) : !rs1z);
      exp_zicsr   = 1;
      exp_rd_we   = 1;
      exp_rd_data = old;
      if (exp_wr) begin
        exp_waddr  = a;
        exp_wdata  = nv;
        ref_csr[a] = nv;
      end
    end
  endtask

  task automatic scramble_inputs(input logic v);
    bus.in_valid    = v;
    bus.in_kind     = 2'($urandom);
    bus.in_funct3   = 3'($urandom);
    bus.in_csr_addr = 12'($urandom);
    bus.in_rs1_val  = $urandom;
    bus.in_zimm     = 5'($urandom);
    bus.in_rs1_zero = 1'($urandom);
    bus.in_pc       = $urandom;
  endtask

  task automatic check_resp(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, ".strobes"}, 32'({csr_write, ecall, mret}), 32'd0);
    chk({tag, ".rd_we"}, 32'(bus.out_rd_we), 32'(exp_rd_we));
    chk({tag, ".redirect"}, 32'(bus.out_redirect), 32'(exp_redirect));
    if (exp_zicsr || exp_ecall) chk({tag, ".rd_data"}, bus.out_rd_data, exp_rd_data);
    if (exp_redirect) chk({tag, ".target"}, bus.out_target, exp_target);
  endtask

  task automatic run_insn(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] zimm,
                          input logic rs1z, input logic [31:0] pc, input int bp);
    predict(kind, f3, a, rs1, zimm, rs1z, pc);
    @(negedge clk);
    bus.in_valid = 1; bus.in_kind = kind; bus.in_funct3 = f3; bus.in_csr_addr = a;
    bus.in_rs1_val = rs1; bus.in_zimm = zimm; bus.in_rs1_zero = rs1z; bus.in_pc = pc;
    chk({tag, ".accept_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 scramble_inputs(1'($urandom));
    @(negedge clk);  // READ
    chk({tag, ".read_addr"}, 32'(csr_read_addr), 32'(exp_raddr));
    chk({tag, ".read_strobes"}, 32'({csr_write, ecall, mret}), 32'd0);
    @(negedge clk);  // WRITE
    chk({tag, ".csr_write"}, 32'(csr_write), 32'(exp_wr));
    chk({tag, ".ecall"}, 32'(ecall), 32'(exp_ecall));
    chk({tag, ".mret"}, 32'(mret), 32'(exp_mret));
    chk({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
    if (exp_wr) begin
      chk({tag, ".waddr"}, 32'(csr_write_addr), 32'(exp_waddr));
      chk({tag, ".wdata"}, csr_data, exp_wdata);
    end
    if (exp_ecall || exp_mret) chk({tag, ".mepc_data"}, mepc_data, exp_mepc);
    if (exp_ecall) chk({tag, ".mcause_data"}, mcause_data, exp_mcause);
    last_wdata = csr_data;
    @(negedge clk);  // RESP
    check_resp(tag);
    last_rd     = bus.out_rd_data;
    last_target = bus.out_target;
    bus.out_ready = 0;
    for (int i = 0; i < bp; i++) begin
      scramble_inputs(1'b1);
      @(posedge clk);
      @(negedge clk);
      check_resp({tag, ".stall"});
    end
    scramble_inputs(1'b0);
    bus.out_ready = 1;
    @(posedge clk);
    #1 bus.out_ready = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    init_val = '{$urandom, $urandom, 32'h0000_1800, 32'h0, 32'h8000_0044, $urandom};
    for (int i = 0; i < 6; i++) ref_csr[legal[i]] = init_val[i];
    scramble_inputs(1'b1);
    bus.out_ready = 1;
    rst = 1;
    load_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state.
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.strobes", 32'({csr_write, ecall, mret}), 32'd0);
    chk("rst.read_addr", 32'(csr_read_addr), 32'd0);
    chk("rst.flags", 32'({bus.out_rd_we, bus.out_redirect}), 32'd0);
    chk("rst.data", csr_data | mepc_data | mcause_data | bus.out_rd_data | bus.out_target
                    | 32'(csr_write_addr), 32'd0);
    rst = 0;
    load_req = 0;
    scramble_inputs(1'b0);
    bus.out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Directed scenarios.
    run_insn("csrrw_mtvec", 2'd0, 3'b001, 12'h305, 32'h8000_0100, 5'd0, 1'b0, 32'h8000_0000, 0);
    chk("csrrw_mtvec.old", last_rd, 32'h0);
    chk("csrrw_mtvec.file", file_mem[12'h305], 32'h8000_0100);
    run_insn("csrrs_x0", 2'd0, 3'b010, 12'h300, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h8000_0004, 0);
    chk("csrrs_x0.rd", last_rd, 32'h1800);
    run_insn("csrrci", 2'd0, 3'b111, 12'h300, 32'h0, 5'h8, 1'b0, 32'h8000_0008, 0);
    chk("csrrci.wdata", last_wdata, 32'h1800);
    run_insn("mret", 2'd2, 3'b000, 12'h302, 32'h0, 5'd0, 1'b0, 32'h8000_0030, 0);
    chk("mret.target", last_target, 32'h8000_0044);
    chk("mret.mepc_kept", file_mem[12'h341], 32'h8000_0044);
    run_insn("ecall", 2'd1, 3'b000, 12'h000, 32'h0, 5'd0, 1'b0, 32'h8000_0040, 0);
    chk("ecall.target", last_target, 32'h8000_0100);
    chk("ecall.mepc", file_mem[12'h341], 32'h8000_0040);
    chk("ecall.mcause", file_mem[12'h342], 32'd11);
    run_insn("bad_addr", 2'd0, 3'b001, 12'h7C0, 32'h1234_5678, 5'd0, 1'b0, 32'h8000_0050, 0);
    chk("bad_addr.target", last_target, 32'h8000_0100);
    chk("bad_addr.mcause", file_mem[12'h342], 32'd2);
    chk("bad_addr.mepc", file_mem[12'h341], 32'h8000_0050);
    run_insn("backpressure", 2'd0, 3'b010, 12'h342, 32'h0000_00F0, 5'd0, 1'b0, 32'h8000_0054, 5);

    // Reset while the write strobe is up.
    @(negedge clk);
    bus.in_valid = 1; bus.in_kind = 2'd0; bus.in_funct3 = 3'b001; bus.in_csr_addr = 12'h300;
    bus.in_rs1_val = 32'hDEAD_BEEF; bus.in_zimm = 5'd0; bus.in_rs1_zero = 1'b0;
    bus.in_pc = 32'h8000_0060;
    @(posedge clk);
    #1 bus.in_valid = 0;
    @(posedge clk);  // enters WRITE
    #1 rst = 1;
    @(negedge clk);
    chk("rst_write.strobes", 32'({csr_write, ecall, mret}), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_write.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_write.csr_kept", file_mem[12'h300], ref_csr[12'h300]);
    repeat (3) begin
      @(negedge clk);
      chk("rst_write.no_resp", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int          r;
      logic [1:0]  k;
      logic [11:0] a;
      r = $urandom_range(0, 9);
      k = (r <= 5 || r == 9) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
      a = ($urandom_range(0, 7) < 7) ? legal[$urandom_range(0, 5)] : 12'($urandom);
      run_insn("rand", k, 3'($urandom), a, $urandom, 5'($urandom),
               ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
    end

    for (int i = 0; i < 6; i++) chk("final_csr", file_mem[legal[i]], ref_csr[legal[i]]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
